// File: rtl/conv1d_design_pkg.sv
// Shared definitions for the streaming 1-D convolution accelerator:
// IF word flag positions, controller states and accumulator sizing.
package conv1d_design_pkg;

   localparam int unsigned IF_W      = 16;
   localparam int unsigned FILT_W    = 16;
   localparam int unsigned PROD_W    = IF_W + FILT_W;
   localparam int unsigned ACC_W     = IF_W + FILT_W + 1;
   localparam int unsigned ROW_END   = 16;
   localparam int unsigned ROW_START = 17;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_F   = 2'd1,
      WAIT_ROW = 2'd2,
      COMPUTE  = 2'd3
   } state_e;

   // Sign-extend a full-width product into the accumulator width.
   function automatic logic [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {p[PROD_W-1], p};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible whenever not empty.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             ren_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_wr_c, do_rd_c;

   always_comb begin
      do_wr_c  = wen_i && !full_q;
      do_rd_c  = ren_i && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr_c) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_rd_c) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_wr_c, do_rd_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is not reset; contents are only observable through valid pointers.
   always_ff @(posedge clk) begin
      if (do_wr_c) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/conv1d_design_top.sv
// Streaming 1-D convolution: loads a filter bank, then for every flagged IF row
// emits the signed dot product of each filter with each strided window.
module conv1d_design_top
   import conv1d_design_pkg::*;
#(
   parameter int unsigned FILT_ADDR_LEN       = 4,
   parameter int unsigned IF_ADDR_LEN         = 4,
   parameter int unsigned IF_SCRATCH_DEPTH    = 12,
   parameter int unsigned IF_SCRATCH_WIDTH    = 16,
   parameter int unsigned FILT_SCRATCH_DEPTH  = 12,
   parameter int unsigned FILT_SCRATCH_WIDTH  = 16,
   parameter int unsigned IF_par_write        = 1,
   parameter int unsigned filter_par_write    = 1,
   parameter int unsigned outbuf_par_read     = 1,
   parameter int unsigned IF_BUFFER_DEPTH     = 64,
   parameter int unsigned FILT_BUFFER_DEPTH   = 64,
   parameter int unsigned OUT_BUFFER_DEPTH    = 64,
   parameter int unsigned P_SUM_ADDR_LEN      = 4,
   parameter int unsigned P_SUM_SCRATCH_WIDTH = 16,
   parameter int unsigned P_SUM_SCRATCH_DEPTH = 24,
   parameter int unsigned P_SUM_PAR_WRITE     = 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic                                      IF_wen,
   input  logic [IF_SCRATCH_WIDTH*IF_par_write+1:0]  IF_din,
   input  logic                                      filter_wen,
   input  logic [FILT_SCRATCH_WIDTH*filter_par_write-1:0] filter_din,
   input  logic                                      outbuf_ren,
   output logic [ACC_W*outbuf_par_read-1:0]          outbuf_dout,
   output logic                                      IF_full,
   output logic                                      IF_empty,
   output logic                                      filter_full,
   output logic                                      filter_empty,
   output logic                                      outbuf_full,
   output logic                                      outbuf_empty,
   input  logic [FILT_ADDR_LEN-1:0]                  filt_len,
   input  logic [IF_ADDR_LEN-1:0]                    stride_len
);

   localparam int unsigned IFW_W      = IF_SCRATCH_WIDTH * IF_par_write + 2;
   localparam int unsigned FW_W       = FILT_SCRATCH_WIDTH * filter_par_write;
   localparam int unsigned OW_W       = ACC_W * outbuf_par_read;
   localparam int unsigned IF_IDX_W   = $clog2(IF_SCRATCH_DEPTH);
   localparam int unsigned IF_CNT_W   = $clog2(IF_SCRATCH_DEPTH + 1);
   localparam int unsigned FILT_IDX_W = $clog2(FILT_SCRATCH_DEPTH);
   localparam int unsigned FILT_CNT_W = $clog2(FILT_SCRATCH_DEPTH + 1);
   localparam int unsigned CW         = IF_CNT_W + FILT_CNT_W + FILT_ADDR_LEN + IF_ADDR_LEN;

   // Only single-word FIFO access and 16-bit operands are implemented.
   if (IF_par_write != 1 || filter_par_write != 1 || outbuf_par_read != 1 ||
       IF_SCRATCH_WIDTH != IF_W || FILT_SCRATCH_WIDTH != FILT_W ||
       P_SUM_PAR_WRITE != 1 || P_SUM_ADDR_LEN == 0 ||
       P_SUM_SCRATCH_WIDTH == 0 || P_SUM_SCRATCH_DEPTH == 0) begin : g_bad_params
      $error("conv1d_design_top: unsupported parameter combination");
   end

   logic [IFW_W-1:0] if_dout_c;
   logic [FW_W-1:0]  filt_dout_c;
   logic             if_pop_c, filt_pop_c, out_push_c;
   logic             if_we_c, filt_we_c;
   logic [IF_IDX_W-1:0] if_waddr_c;

   sync_fifo #(.WIDTH(IFW_W), .DEPTH(IF_BUFFER_DEPTH)) u_if_fifo (
      .clk     (clk),
      .rst     (rst),
      .wen_i   (IF_wen),
      .din_i   (IF_din),
      .ren_i   (if_pop_c),
      .dout_o  (if_dout_c),
      .full_o  (IF_full),
      .empty_o (IF_empty)
   );

   sync_fifo #(.WIDTH(FW_W), .DEPTH(FILT_BUFFER_DEPTH)) u_filt_fifo (
      .clk     (clk),
      .rst     (rst),
      .wen_i   (filter_wen),
      .din_i   (filter_din),
      .ren_i   (filt_pop_c),
      .dout_o  (filt_dout_c),
      .full_o  (filter_full),
      .empty_o (filter_empty)
   );

   logic [ACC_W-1:0] sum_c;

   sync_fifo #(.WIDTH(OW_W), .DEPTH(OUT_BUFFER_DEPTH)) u_out_fifo (
      .clk     (clk),
      .rst     (rst),
      .wen_i   (out_push_c),
      .din_i   (OW_W'(sum_c)),
      .ren_i   (outbuf_ren),
      .dout_o  (outbuf_dout),
      .full_o  (outbuf_full),
      .empty_o (outbuf_empty)
   );

   // Scratchpads
   logic signed [IF_SCRATCH_WIDTH-1:0]   if_mem_q   [IF_SCRATCH_DEPTH];
   logic signed [FILT_SCRATCH_WIDTH-1:0] filt_mem_q [FILT_SCRATCH_DEPTH];

   state_e                  state_q, state_d;
   logic [FILT_ADDR_LEN-1:0] len_q, len_d;
   logic [FILT_ADDR_LEN-1:0] k_q, k_d;
   logic [IF_ADDR_LEN-1:0]   stride_q, stride_d;
   logic [FILT_CNT_W-1:0]    words_q, words_d;
   logic [FILT_CNT_W-1:0]    nf_q, nf_d;
   logic [FILT_CNT_W-1:0]    f_q, f_d;
   logic [FILT_CNT_W-1:0]    fbase_q, fbase_d;
   logic [IF_CNT_W-1:0]      p_q, p_d;
   logic [IF_CNT_W-1:0]      row_len_q, row_len_d;
   logic                     in_row_q, in_row_d;
   logic [ACC_W-1:0]         acc_q, acc_d;

   logic [IF_IDX_W-1:0]              x_idx_c;
   logic [FILT_IDX_W-1:0]            w_idx_c;
   logic signed [IF_SCRATCH_WIDTH-1:0]   x_c;
   logic signed [FILT_SCRATCH_WIDTH-1:0] w_c;
   logic signed [PROD_W-1:0]         prod_c;
   logic [CW-1:0]                    next_p_c;
   logic                             last_k_c, row_ok_c;

   // MAC datapath: one tap of the current window per cycle
   always_comb begin
      x_idx_c  = IF_IDX_W'(CW'(p_q) + CW'(k_q));
      w_idx_c  = FILT_IDX_W'(CW'(fbase_q) + CW'(k_q));
      x_c      = if_mem_q[x_idx_c];
      w_c      = filt_mem_q[w_idx_c];
      prod_c   = PROD_W'(x_c) * PROD_W'(w_c);
      sum_c    = (k_q == '0) ? sext_prod(prod_c) : acc_q + sext_prod(prod_c);
      last_k_c = (k_q == len_q - FILT_ADDR_LEN'(1));
      next_p_c = CW'(p_q) + CW'(stride_q);
      row_ok_c = (len_q != '0) && (nf_q != '0) && (CW'(len_q) <= CW'(row_len_q));
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      stride_d   = stride_q;
      k_d        = k_q;
      words_d    = words_q;
      nf_d       = nf_q;
      f_d        = f_q;
      fbase_d    = fbase_q;
      p_d        = p_q;
      row_len_d  = row_len_q;
      in_row_d   = in_row_q;
      acc_d      = acc_q;
      if_pop_c   = 1'b0;
      filt_pop_c = 1'b0;
      out_push_c = 1'b0;
      if_we_c    = 1'b0;
      filt_we_c  = 1'b0;
      if_waddr_c = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               len_d    = filt_len;
               stride_d = stride_len;
               k_d      = '0;
               words_d  = '0;
               nf_d     = '0;
               in_row_d = 1'b0;
               state_d  = LOAD_F;
            end
         end

         // Keep loading whole filters while another one still fits.
         LOAD_F: begin
            if (k_q == '0 && (len_q == '0 ||
                CW'(words_q) + CW'(len_q) > CW'(FILT_SCRATCH_DEPTH))) begin
               state_d = WAIT_ROW;
            end else if (!filter_empty) begin
               filt_pop_c = 1'b1;
               filt_we_c  = 1'b1;
               words_d    = words_q + FILT_CNT_W'(1);
               if (last_k_c) begin
                  k_d  = '0;
                  nf_d = nf_q + FILT_CNT_W'(1);
               end else begin
                  k_d = k_q + FILT_ADDR_LEN'(1);
               end
            end
         end

         WAIT_ROW: begin
            if (!IF_empty) begin
               if_pop_c = 1'b1;
               if (if_dout_c[ROW_START]) begin
                  if_we_c   = 1'b1;
                  if_waddr_c = '0;
                  row_len_d = IF_CNT_W'(1);
                  in_row_d  = 1'b1;
               end else if (in_row_q && CW'(row_len_q) < CW'(IF_SCRATCH_DEPTH)) begin
                  if_we_c    = 1'b1;
                  if_waddr_c = IF_IDX_W'(row_len_q);
                  row_len_d  = row_len_q + IF_CNT_W'(1);
               end
               if (if_dout_c[ROW_END] && (if_dout_c[ROW_START] || in_row_q)) begin
                  in_row_d = 1'b0;
                  f_d      = '0;
                  fbase_d  = '0;
                  p_d      = '0;
                  k_d      = '0;
                  state_d  = COMPUTE;
               end
            end
         end

         // Filter-major sweep; stall on the final tap while the result cannot be pushed.
         COMPUTE: begin
            if (!row_ok_c) begin
               state_d = WAIT_ROW;
            end else if (!(last_k_c && outbuf_full)) begin
               acc_d = sum_c;
               if (!last_k_c) begin
                  k_d = k_q + FILT_ADDR_LEN'(1);
               end else begin
                  out_push_c = 1'b1;
                  k_d        = '0;
                  if (stride_q != '0 && next_p_c + CW'(len_q) <= CW'(row_len_q)) begin
                     p_d = IF_CNT_W'(next_p_c);
                  end else begin
                     p_d = '0;
                     if (CW'(f_q) + CW'(1) >= CW'(nf_q)) begin
                        state_d = WAIT_ROW;
                     end else begin
                        f_d     = f_q + FILT_CNT_W'(1);
                        fbase_d = fbase_q + FILT_CNT_W'(len_q);
                     end
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         stride_q  <= '0;
         k_q       <= '0;
         words_q   <= '0;
         nf_q      <= '0;
         f_q       <= '0;
         fbase_q   <= '0;
         p_q       <= '0;
         row_len_q <= '0;
         in_row_q  <= 1'b0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         stride_q  <= stride_d;
         k_q       <= k_d;
         words_q   <= words_d;
         nf_q      <= nf_d;
         f_q       <= f_d;
         fbase_q   <= fbase_d;
         p_q       <= p_d;
         row_len_q <= row_len_d;
         in_row_q  <= in_row_d;
         acc_q     <= acc_d;
      end
   end

   // Scratchpads keep their contents across reset.
   always_ff @(posedge clk) begin
      if (if_we_c) begin
         if_mem_q[if_waddr_c] <= if_dout_c[IF_SCRATCH_WIDTH-1:0];
      end
      if (filt_we_c) begin
         filt_mem_q[FILT_IDX_W'(words_q)] <= filt_dout_c;
      end
   end

endmodule

// File: tb/tb_conv1d_design_top.sv
// Directed plus randomized bench for conv1d_design_top against a
// dot-product reference model built from the filter bank and row contents.
module tb_conv1d_design_top;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        IF_wen;
   logic [17:0] IF_din;
   logic        filter_wen;
   logic [15:0] filter_din;
   logic        outbuf_ren;
   logic [32:0] outbuf_dout;
   logic        IF_full, IF_empty, filter_full, filter_empty, outbuf_full, outbuf_empty;
   logic [3:0]  filt_len;
   logic [3:0]  stride_len;

   int vectors     = 0;
   int miscompares = 0;

   int          filt_m [12];
   int          cur_l, cur_s;
   int          row_q [$];
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   conv1d_design_top dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .IF_wen       (IF_wen),
      .IF_din       (IF_din),
      .filter_wen   (filter_wen),
      .filter_din   (filter_din),
      .outbuf_ren   (outbuf_ren),
      .outbuf_dout  (outbuf_dout),
      .IF_full      (IF_full),
      .IF_empty     (IF_empty),
      .filter_full  (filter_full),
      .filter_empty (filter_empty),
      .outbuf_full  (outbuf_full),
      .outbuf_empty (outbuf_empty),
      .filt_len     (filt_len),
      .stride_len   (stride_len)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rnd16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   task automatic push_filter(input int v);
      filter_din = 16'(v);
      filter_wen = 1'b1;
      tick();
      filter_wen = 1'b0;
   endtask

   task automatic push_if(input int v, input logic s, input logic e);
      IF_din = {s, e, 16'(v)};
      IF_wen = 1'b1;
      tick();
      IF_wen = 1'b0;
   endtask

   // Reference: every filter against every strided window, filter-major, 33-bit wrap.
   task automatic model_row();
      int      n;
      int      nf;
      longint  acc;
      n  = (row_q.size() > 12) ? 12 : row_q.size();
      nf = 12 / cur_l;
      for (int f = 0; f < nf; f++) begin
         for (int p = 0; p + cur_l <= n; p += cur_s) begin
            acc = 0;
            for (int k = 0; k < cur_l; k++) begin
               acc += longint'(filt_m[f*cur_l + k]) * longint'(row_q[p + k]);
            end
            exp_q.push_back(33'(acc));
         end
      end
   endtask

   task automatic send_row(input bit use_model);
      for (int i = 0; i < row_q.size(); i++) begin
         push_if(row_q[i], (i == 0), (i == row_q.size() - 1));
      end
      if (use_model) model_row();
   endtask

   task automatic start_run(input int l, input int s);
      filt_len   = 4'(l);
      stride_len = 4'(s);
      cur_l      = l;
      cur_s      = s;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic load_filters();
      for (int i = 0; i < (12 / cur_l) * cur_l; i++) push_filter(filt_m[i]);
   endtask

   task automatic pop_check(input string tag, input logic [32:0] exp);
      int n;
      n = 0;
      while (outbuf_empty && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check({tag, "_timeout"}, outbuf_empty, 33'd0);
      check(tag, outbuf_dout, exp);
      if (!outbuf_empty) begin
         outbuf_ren = 1'b1;
         tick();
         outbuf_ren = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_check(tag, exp_q.pop_front());
      repeat (40) tick();
      check({tag, "_empty"}, outbuf_empty, 33'd1);
   endtask

   task automatic push_row1_expected();
      int r1 [6];
      r1 = '{-1492, 4398, 3577, 3829, 997, -4715};
      for (int i = 0; i < 6; i++) exp_q.push_back(33'(r1[i]));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; IF_wen = 1'b0; IF_din = '0;
      filter_wen = 1'b0; filter_din = '0; outbuf_ren = 1'b0;
      filt_len = '0; stride_len = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_if_empty",   IF_empty,     33'd1);
      check("rst_f_empty",    filter_empty, 33'd1);
      check("rst_o_empty",    outbuf_empty, 33'd1);
      check("rst_if_full",    IF_full,      33'd0);
      check("rst_f_full",     filter_full,  33'd0);
      check("rst_o_full",     outbuf_full,  33'd0);
      check("rst_dout",       outbuf_dout,  33'd0);

      // Row 1 arrives before the filters finish loading
      filt_m = '{-41, -55, 30, 48, -37, 52, 8, 32, 44, 49, -28, -52};
      start_run(4, 2);
      row_q = '{-41, 41, -45, 9, 28, 46};
      send_row(0);
      push_row1_expected();
      load_filters();
      drain("row1");

      // Row 2 with its known leading results
      row_q = '{29, -56, -10, 42, -48, -62};
      send_row(1);
      pop_check("row2_r0", 33'(3607));
      pop_check("row2_r1", 33'(-6316));
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      drain("row2");

      // Rows shorter than the filter produce nothing
      row_q = '{5, 6, 7};
      send_row(1);
      row_q = '{9};
      send_row(1);
      repeat (40) tick();
      check("short_none", outbuf_empty, 33'd1);
      row_q = '{29, -56, -10, 42, -48, -62};
      send_row(1);
      drain("after_short");

      // Words outside a row are discarded
      push_if(123, 1'b0, 1'b0);
      push_if(77, 1'b0, 1'b1);
      repeat (20) tick();
      check("stray_none", outbuf_empty, 33'd1);
      check("stray_popped", IF_empty, 33'd1);
      row_q = '{-41, 41, -45, 9, 28, 46};
      send_row(1);
      drain("after_stray");

      // Output backpressure: 5 rows x 15 results overflow the 64-deep FIFO
      for (int r = 0; r < 5; r++) begin
         row_q.delete();
         for (int i = 0; i < 12; i++) row_q.push_back(rnd16());
         send_row(1);
      end
      n = 0;
      while (!outbuf_full && n < 3000) begin
         tick();
         n++;
      end
      check("bp_full", outbuf_full, 33'd1);
      repeat (30) tick();
      check("bp_still_full", outbuf_full, 33'd1);
      drain("bp");

      // Reset mid-row clears all FIFOs
      row_q = '{-41, 41, -45, 9, 28, 46};
      send_row(0);
      repeat (20) tick();
      push_if(1, 1'b1, 1'b0);
      push_if(2, 1'b0, 1'b0);
      push_filter(5);
      rst = 1'b1;
      #1;
      check("mid_rst_if_empty", IF_empty,     33'd1);
      check("mid_rst_f_empty",  filter_empty, 33'd1);
      check("mid_rst_o_empty",  outbuf_empty, 33'd1);
      check("mid_rst_dout",     outbuf_dout,  33'd0);
      tick();
      rst = 1'b0;
      tick();
      start_run(4, 2);
      load_filters();
      row_q = '{-41, 41, -45, 9, 28, 46};
      send_row(0);
      push_row1_expected();
      drain("restart_row1");

      // Randomized filter length, stride, coefficients and row lengths
      for (int cfg = 0; cfg < 3; cfg++) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         tick();
         for (int i = 0; i < 12; i++) filt_m[i] = rnd16();
         start_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)));
         load_filters();
         for (int r = 0; r < 4; r++) begin
            row_q.delete();
            n = int'($urandom_range(1, 14));
            for (int i = 0; i < n; i++) row_q.push_back(rnd16());
            send_row(1);
         end
         drain("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
